// File: rtl/tanh_pkg.sv
// Shared types and constants for the tanh front-end sequencer.
// The SAT state exists only when TANH_SAT_BYPASS_EN is defined.
package tanh_pkg;

    localparam int A_MOD_W        = 17;
    localparam int RES_W          = 16;
    localparam int DEF_LUT_LAT    = 2;
    localparam int DEF_INTERP_LAT = 3;

    localparam logic [A_MOD_W-1:0] SAT_VALUE = 17'h0FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_INTERP,
        ST_DONE
`ifdef TANH_SAT_BYPASS_EN
        ,
        ST_SAT
`endif
    } state_t;

endpackage

// File: rtl/tanh_abs_sat.sv
// Combinational operand conditioning: sign extract, absolute value,
// range check and clamp to the 17-bit datapath magnitude (TANH_SAT_BYPASS_EN exposes o_oor).
module tanh_abs_sat
    import tanh_pkg::*;
#(
    parameter int IN_W = 20
) (
    input  logic [IN_W-1:0]    i_x,
    output logic               o_sign,
`ifdef TANH_SAT_BYPASS_EN
    output logic               o_oor,
`endif
    output logic [A_MOD_W-1:0] o_aMod
);

    logic [IN_W-1:0] w_mag;
    logic            w_oor;

    // The magnitude keeps the full operand width, so the most negative input
    // maps to 2^(IN_W-1) and is then caught by the range check.
    assign o_sign = i_x[IN_W-1];
    assign w_mag  = i_x[IN_W-1] ? (-i_x) : i_x;
    assign w_oor  = |w_mag[IN_W-1:A_MOD_W];
    assign o_aMod = w_oor ? {A_MOD_W{1'b1}} : w_mag[A_MOD_W-1:0];

`ifdef TANH_SAT_BYPASS_EN
    assign o_oor = w_oor;
`endif

endmodule

// File: rtl/tanh_sequencer.sv
// Front-end controller for the piecewise-linear tanh datapath: accepts one operand,
// sequences the LUT and interpolation phases, restores the sign (TANH_SAT_BYPASS_EN adds SAT).
module tanh_sequencer
    import tanh_pkg::*;
#(
    parameter int IN_W       = 20,
    parameter int LUT_LAT    = DEF_LUT_LAT,
    parameter int INTERP_LAT = DEF_INTERP_LAT
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_x,
    output logic [16:0]     a_mod,
    output logic            start_tanh,
    output logic            start_interpolation,
    input  logic [15:0]     tanh_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [16:0]     out_data,
    output logic            busy
);

    state_t               r_state;
    state_t               w_nextState;
    logic [15:0]          r_cnt;
    logic [A_MOD_W-1:0]   r_aMod;
    logic                 r_sign;
    logic [A_MOD_W-1:0]   r_outData;
    logic                 r_rdyEn;
    logic                 w_sign;
    logic [A_MOD_W-1:0]   w_aMod;
    logic                 w_accept;
`ifdef TANH_SAT_BYPASS_EN
    logic                 w_oor;
`endif

    tanh_abs_sat #(
        .IN_W   (IN_W)
    ) u_absSat (
        .i_x    (in_x),
        .o_sign (w_sign),
`ifdef TANH_SAT_BYPASS_EN
        .o_oor  (w_oor),
`endif
        .o_aMod (w_aMod)
    );

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
`ifdef TANH_SAT_BYPASS_EN
                    w_nextState = w_oor ? ST_SAT : ST_LOOKUP;
`else
                    w_nextState = ST_LOOKUP;
`endif
                end
            end
            ST_LOOKUP: begin
                if (r_cnt == 16'd0) begin
                    w_nextState = ST_INTERP;
                end
            end
            ST_INTERP: begin
                if (r_cnt == 16'd0) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
`ifdef TANH_SAT_BYPASS_EN
            ST_SAT: begin
                if (out_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
`endif
            default: w_nextState = ST_IDLE;
        endcase
    end

    // in_ready stays low through reset and for the first edge after release.
    always_comb begin
        in_ready            = 1'b0;
        start_tanh          = 1'b0;
        start_interpolation = 1'b0;
        out_valid           = 1'b0;
        busy                = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:   in_ready            = r_rdyEn;
            ST_LOOKUP: start_tanh          = 1'b1;
            ST_INTERP: start_interpolation = 1'b1;
            ST_DONE:   out_valid           = 1'b1;
`ifdef TANH_SAT_BYPASS_EN
            ST_SAT:    out_valid           = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdyEn <= 1'b0;
        end else begin
            r_rdyEn <= 1'b1;
        end
    end

    // One down-counter serves both phases; it is reloaded at each phase entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= 16'd0;
            r_aMod    <= '0;
            r_sign    <= 1'b0;
            r_outData <= '0;
        end else if (w_accept) begin
            r_cnt  <= 16'(LUT_LAT - 1);
            r_aMod <= w_aMod;
            r_sign <= w_sign;
`ifdef TANH_SAT_BYPASS_EN
            if (w_oor) begin
                r_outData <= w_sign ? (-SAT_VALUE) : SAT_VALUE;
            end
`endif
        end else if (r_state == ST_LOOKUP) begin
            if (r_cnt == 16'd0) begin
                r_cnt <= 16'(INTERP_LAT - 1);
            end else begin
                r_cnt <= r_cnt - 16'd1;
            end
        end else if (r_state == ST_INTERP) begin
            if (r_cnt == 16'd0) begin
                r_outData <= r_sign ? (-{1'b0, tanh_result}) : {1'b0, tanh_result};
            end else begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    assign a_mod    = r_aMod;
    assign out_data = r_outData;

endmodule
